// File: rtl/commit_tracer_pkg.sv
// Shared types and constants for the commit tracer.
// Record layout: six 32-bit trace words; word 2 carries the packed flag byte.
package commit_tracer_pkg;

  localparam int unsigned TraceWords   = 6;
  localparam int unsigned RecWidth     = 168;

  // Bit positions inside the flags byte (trace word 2).
  localparam int unsigned FlagRegWe    = 0;
  localparam int unsigned FlagRegWaLsb = 1;
  localparam int unsigned FlagRegWaMsb = 5;
  localparam int unsigned FlagDmemWe   = 6;
  localparam int unsigned FlagHalt     = 7;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [7:0]  flags;
    logic [31:0] reg_wd;
    logic [31:0] dmem_wa;
    logic [31:0] dmem_wd;
  } trace_rec_t;

  typedef enum logic {StIdle, StSend} out_state_e;

  // Select one 32-bit word of a record in streaming order.
  function automatic logic [31:0] rec_word(input trace_rec_t rec, input logic [2:0] idx);
    logic [31:0] w;
    case (idx)
      3'd0:    w = rec.pc;
      3'd1:    w = rec.inst;
      3'd2:    w = {24'b0, rec.flags};
      3'd3:    w = rec.reg_wd;
      3'd4:    w = rec.dmem_wa;
      default: w = rec.dmem_wd;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/commit_tracer_fifo.sv
// trace_fifo: synchronous FIFO with clear.
// Ports: clk, rst_n (async active-low), clr (sync, beats push/pop), push/wdata,
// pop/rdata (head, combinational), count, full, empty.
module trace_fifo #(
  parameter int unsigned WIDTH = 168,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count = wptr_q - rptr_q;
  assign rdata = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/commit_tracer.sv
// commit_tracer: captures each newly retired instruction from the CPU commit
// interface into a FIFO and streams it as six 32-bit words (valid/ready).
// Inputs: clk, rst_n, global_en, commit + commit_* record fields, trace_clr, trace_ready.
// Outputs: cpu_stall, trace_valid/trace_data/trace_last, done, overflow, drop_cnt, commit_cnt.
module commit_tracer
  import commit_tracer_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter bit          STALL_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        global_en,
  input  logic        commit,
  input  logic [31:0] commit_pc,
  input  logic [31:0] commit_inst,
  input  logic        commit_halt,
  input  logic        commit_reg_we,
  input  logic [4:0]  commit_reg_wa,
  input  logic [31:0] commit_reg_wd,
  input  logic        commit_dmem_we,
  input  logic [31:0] commit_dmem_wa,
  input  logic [31:0] commit_dmem_wd,
  input  logic        trace_clr,
  output logic        cpu_stall,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_data,
  output logic        trace_last,
  output logic        done,
  output logic        overflow,
  output logic [15:0] drop_cnt,
  output logic [31:0] commit_cnt
);

  localparam int unsigned     CntW       = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] StallLevel = CntW'(DEPTH - 1);
  localparam logic [2:0]      LastWord   = 3'(TraceWords - 1);

  logic            en_d_q, halted_q, overflow_q;
  logic [15:0]     drop_cnt_q;
  logic [31:0]     commit_cnt_q;
  logic [2:0]      word_idx_q, word_idx_d;
  out_state_e      state_q, state_d;
  trace_rec_t      rec_in, rec_head;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic            new_commit, capture, accept, drop, xfer;

  // Commit registers hold while global_en is low; only the cycle after an
  // enabled edge carries a fresh record.
  assign new_commit = commit & en_d_q;
  assign capture    = new_commit & ~halted_q;
  assign xfer       = trace_valid & trace_ready;
  assign fifo_pop   = xfer & (word_idx_q == LastWord);
  // A full FIFO still takes the record when the head leaves on the same edge.
  assign accept     = capture & (~fifo_full | fifo_pop);
  assign drop       = capture & ~accept;
  assign fifo_push  = accept;

  always_comb begin
    rec_in          = '0;
    rec_in.pc       = commit_pc;
    rec_in.inst     = commit_inst;
    rec_in.reg_wd   = commit_reg_wd;
    rec_in.dmem_wa  = commit_dmem_wa;
    rec_in.dmem_wd  = commit_dmem_wd;
    rec_in.flags[FlagRegWe]                  = commit_reg_we;
    rec_in.flags[FlagRegWaMsb:FlagRegWaLsb]  = commit_reg_wa;
    rec_in.flags[FlagDmemWe]                 = commit_dmem_we;
    rec_in.flags[FlagHalt]                   = commit_halt;
  end

  trace_fifo #(
    .WIDTH(RecWidth),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (trace_clr),
    .push (fifo_push),
    .wdata(rec_in),
    .pop  (fifo_pop),
    .rdata(rec_head),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    unique case (state_q)
      StIdle: if (!fifo_empty) state_d = StSend;
      StSend: begin
        if (xfer) begin
          if (word_idx_q == LastWord) begin
            word_idx_d = '0;
            // Leave SEND only if the popped head was the last entry.
            if (fifo_count == CntW'(1) && !fifo_push) state_d = StIdle;
          end else begin
            word_idx_d = word_idx_q + 3'd1;
          end
        end
      end
    endcase
    if (trace_clr) begin
      state_d    = StIdle;
      word_idx_d = '0;
    end
  end

  assign trace_valid = (state_q == StSend);
  assign trace_last  = trace_valid & (word_idx_q == LastWord);
  assign trace_data  = trace_valid ? rec_word(rec_head, word_idx_q) : 32'h0;
  // Threshold one below full absorbs the record already launched when stall rises.
  assign cpu_stall   = STALL_EN & (fifo_count >= StallLevel);
  assign done        = halted_q & fifo_empty & (state_q == StIdle);
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_cnt_q;
  assign commit_cnt  = commit_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_d_q       <= 1'b0;
      state_q      <= StIdle;
      word_idx_q   <= '0;
      halted_q     <= 1'b0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
      commit_cnt_q <= '0;
    end else begin
      en_d_q     <= global_en;
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      if (trace_clr) begin
        halted_q     <= 1'b0;
        overflow_q   <= 1'b0;
        drop_cnt_q   <= '0;
        commit_cnt_q <= '0;
      end else begin
        if (accept) begin
          commit_cnt_q <= commit_cnt_q + 32'd1;
          if (commit_halt) halted_q <= 1'b1;
        end
        if (drop) begin
          overflow_q <= 1'b1;
          if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_commit_tracer.sv
// Self-checking bench for commit_tracer: a CPU-side driver, a transaction-level
// reference model checked every cycle, and directed scenarios with literal values.
module tb_commit_tracer;

  localparam int DEPTH = 8;

  logic        clk, rst_n, global_en, commit, commit_halt, commit_reg_we, commit_dmem_we;
  logic [31:0] commit_pc, commit_inst, commit_reg_wd, commit_dmem_wa, commit_dmem_wd;
  logic [4:0]  commit_reg_wa;
  logic        trace_clr, cpu_stall, trace_valid, trace_ready, trace_last, done, overflow;
  logic [31:0] trace_data, commit_cnt;
  logic [15:0] drop_cnt;

  // CPU-side knobs
  logic        cpu_run, gate_stall, nxt_commit, nxt_halt;
  bit          fix_mode, rnd_mode;
  logic [31:0] fx_pc, fx_inst, fx_reg_wd;
  logic [4:0]  fx_reg_wa;
  logic        fx_reg_we;
  int          loads;

  assign global_en = cpu_run & ~(gate_stall & cpu_stall);

  commit_tracer #(.DEPTH(DEPTH), .STALL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .global_en(global_en), .commit(commit),
    .commit_pc(commit_pc), .commit_inst(commit_inst), .commit_halt(commit_halt),
    .commit_reg_we(commit_reg_we), .commit_reg_wa(commit_reg_wa),
    .commit_reg_wd(commit_reg_wd), .commit_dmem_we(commit_dmem_we),
    .commit_dmem_wa(commit_dmem_wa), .commit_dmem_wd(commit_dmem_wd),
    .trace_clr(trace_clr), .cpu_stall(cpu_stall), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_data(trace_data), .trace_last(trace_last),
    .done(done), .overflow(overflow), .drop_cnt(drop_cnt), .commit_cnt(commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc, inst, reg_wd, dmem_wa, dmem_wd;
    logic        halt, dmem_we, reg_we;
    logic [4:0]  reg_wa;
  } rec_t;

  rec_t        m_q[$];
  int          m_widx;
  bit          m_vld, m_halted, m_ovf, m_en_d;
  int          m_drop;
  logic [31:0] m_cnt;
  logic [31:0] got_w[$];
  bit          got_l[$];
  int          n_cmp, n_err;

  function automatic logic [31:0] word_of(rec_t r, int i);
    case (i)
      0: return r.pc;
      1: return r.inst;
      2: return {24'b0, r.halt, r.dmem_we, r.reg_wa, r.reg_we};
      3: return r.reg_wd;
      4: return r.dmem_wa;
      default: return r.dmem_wd;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_widx = 0; m_vld = 0; m_halted = 0; m_ovf = 0; m_en_d = 0; m_drop = 0; m_cnt = 0;
  endtask

  // Compare on the falling edge, then advance the model to the next rising edge.
  initial begin
    bit   nw, xfer, pop, acc;
    int   sz0;
    rec_t r;
    n_cmp = 0; n_err = 0;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
        chk("rst_valid", 32'(trace_valid), 0);
        chk("rst_stall", 32'(cpu_stall), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cnt", commit_cnt, 0);
        chk("rst_data", trace_data, 0);
        continue;
      end
      chk("valid", 32'(trace_valid), 32'(m_vld));
      if (m_vld) chk("data", trace_data, word_of(m_q[0], m_widx));
      chk("last", 32'(trace_last), 32'(m_vld && m_widx == 5));
      chk("stall", 32'(cpu_stall), 32'(m_q.size() >= DEPTH - 1));
      chk("done", 32'(done), 32'(m_halted && m_q.size() == 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      chk("commit_cnt", commit_cnt, m_cnt);
      if (trace_valid && trace_ready) begin
        got_w.push_back(trace_data);
        got_l.push_back(trace_last);
      end
      nw   = commit && m_en_d;
      xfer = m_vld && trace_ready;
      pop  = xfer && m_widx == 5;
      sz0  = m_q.size();
      if (trace_clr) begin
        m_q.delete();
        m_widx = 0; m_vld = 0; m_halted = 0; m_ovf = 0; m_drop = 0; m_cnt = 0;
      end else begin
        if (xfer) begin
          if (pop) begin
            void'(m_q.pop_front());
            m_widx = 0;
          end else m_widx++;
        end
        if (nw && !m_halted) begin
          acc = (sz0 < DEPTH) || pop;
          if (acc) begin
            r.pc = commit_pc; r.inst = commit_inst; r.halt = commit_halt;
            r.reg_we = commit_reg_we; r.reg_wa = commit_reg_wa; r.reg_wd = commit_reg_wd;
            r.dmem_we = commit_dmem_we; r.dmem_wa = commit_dmem_wa; r.dmem_wd = commit_dmem_wd;
            m_q.push_back(r);
            m_cnt = m_cnt + 1;
            if (commit_halt) m_halted = 1;
          end else begin
            m_ovf = 1;
            if (m_drop < 16'hFFFF) m_drop++;
          end
        end
        m_vld = (sz0 > 0) && (m_q.size() > 0);
      end
      m_en_d = global_en;
    end
  end

  // ---------------- CPU commit register model ----------------
  initial begin
    bit g;
    commit = 0; commit_halt = 0; commit_pc = 0; commit_inst = 0; commit_reg_we = 0;
    commit_reg_wa = 0; commit_reg_wd = 0; commit_dmem_we = 0; commit_dmem_wa = 0;
    commit_dmem_wd = 0; loads = 0;
    forever begin
      @(negedge clk);
      g = global_en;
      @(posedge clk);
      #1;
      if (g && rst_n) begin
        commit      = rnd_mode ? ($urandom_range(0, 3) != 0) : nxt_commit;
        commit_halt = rnd_mode ? ($urandom_range(0, 47) == 0) : nxt_halt;
        if (fix_mode) begin
          commit_pc = fx_pc; commit_inst = fx_inst; commit_reg_we = fx_reg_we;
          commit_reg_wa = fx_reg_wa; commit_reg_wd = fx_reg_wd;
          commit_dmem_we = 0; commit_dmem_wa = 0; commit_dmem_wd = 0;
        end else begin
          commit_pc = $urandom; commit_inst = $urandom; commit_reg_we = 1'($urandom);
          commit_reg_wa = 5'($urandom); commit_reg_wd = $urandom;
          commit_dmem_we = 1'($urandom); commit_dmem_wa = $urandom; commit_dmem_wd = $urandom;
        end
        if (commit) loads++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expire(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  task automatic do_clr();
    trace_clr = 1; step(1); trace_clr = 0;
  endtask

  task automatic retire(input int n, input int halt_at);
    int base, guard;
    base = loads; guard = 0;
    nxt_commit = 1; nxt_halt = (halt_at == 0);
    while (loads < base + n && guard < 200) begin
      step(1); guard++;
      nxt_halt = (loads - base == halt_at);
    end
    nxt_commit = 0; nxt_halt = 0;
    if (guard >= 200) expire("retire");
  endtask

  task automatic drain(input int max);
    int guard;
    guard = 0;
    while ((m_q.size() != 0) && guard < max) begin step(1); guard++; end
    if (guard >= max) expire("drain");
    step(2);
  endtask

  task automatic wait_got(input int target);
    int guard;
    guard = 0;
    while (got_w.size() < target && guard < 100) begin step(1); guard++; end
    if (guard >= 100) expire("wait_got");
  endtask

  initial begin
    int base;
    rst_n = 0; trace_clr = 0; trace_ready = 0; cpu_run = 0; gate_stall = 1;
    nxt_commit = 0; nxt_halt = 0; fix_mode = 0; rnd_mode = 0;
    fx_pc = 0; fx_inst = 0; fx_reg_wd = 0; fx_reg_wa = 0; fx_reg_we = 0;
    step(3);
    chk("reset_cnt", commit_cnt, 0);
    chk("reset_valid", 32'(trace_valid), 0);
    rst_n = 1;
    step(2);

    // single record with known fields
    fix_mode = 1; fx_pc = 32'h0040_0000; fx_inst = 32'h0050_0093;
    fx_reg_we = 1; fx_reg_wa = 5'd1; fx_reg_wd = 32'd5;
    trace_ready = 1; cpu_run = 1;
    base = got_w.size();
    retire(1, -1);
    step(15);
    chk("t1_nrec", 32'(got_w.size() - base), 6);
    chk("t1_w0", got_w[base], 32'h0040_0000);
    chk("t1_w1", got_w[base+1], 32'h0050_0093);
    chk("t1_w2", got_w[base+2], 32'h0000_0003);
    chk("t1_w3", got_w[base+3], 32'h0000_0005);
    chk("t1_w5", got_w[base+5], 32'h0);
    chk("t1_last4", 32'(got_l[base+4]), 0);
    chk("t1_last5", 32'(got_l[base+5]), 1);
    chk("t1_cnt", commit_cnt, 1);

    // held commit is captured once
    do_clr();
    base = got_w.size();
    retire(1, -1);
    cpu_run = 0;
    step(10);
    chk("t2_held", 32'(commit), 1);
    cpu_run = 1;
    drain(50);
    chk("t2_nrec", 32'(got_w.size() - base), 6);
    chk("t2_cnt", commit_cnt, 1);

    // back-pressure with stall gating
    do_clr();
    fix_mode = 0; trace_ready = 0; base = got_w.size();
    nxt_commit = 1;
    step(20);
    nxt_commit = 0;
    chk("t3_cnt", commit_cnt, 8);
    chk("t3_drop", 32'(drop_cnt), 0);
    chk("t3_stall", 32'(cpu_stall), 1);
    trace_ready = 1;
    drain(200);
    chk("t3_nrec", 32'(got_w.size() - base), 48);

    // overflow without stall gating
    do_clr();
    trace_ready = 0; gate_stall = 0;
    retire(10, -1);
    step(3);
    chk("t4_drop", 32'(drop_cnt), 2);
    chk("t4_ovf", 32'(overflow), 1);
    chk("t4_cnt", commit_cnt, 8);
    trace_ready = 1;
    drain(200);
    gate_stall = 1;

    // halt drain
    do_clr();
    fix_mode = 1; fx_pc = 32'h0000_1000; fx_inst = 32'h0010_0073;
    fx_reg_we = 0; fx_reg_wa = 0; fx_reg_wd = 0;
    base = got_w.size();
    retire(5, 2);
    drain(100);
    chk("t5_nrec", 32'(got_w.size() - base), 18);
    chk("t5_inst", got_w[base+13], 32'h0010_0073);
    chk("t5_flags", got_w[base+14], 32'h0000_0080);
    chk("t5_done", 32'(done), 1);
    chk("t5_cnt", commit_cnt, 3);

    // clear mid-record
    do_clr();
    fix_mode = 0; base = got_w.size();
    retire(2, -1);
    wait_got(base + 3);
    trace_ready = 0; trace_clr = 1;
    step(1);
    trace_clr = 0;
    @(negedge clk);
    chk("t6_valid", 32'(trace_valid), 0);
    chk("t6_cnt", commit_cnt, 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_ovf", 32'(overflow), 0);

    // async reset mid-record
    step(1);
    trace_ready = 1; base = got_w.size();
    retire(1, -1);
    wait_got(base + 3);
    rst_n = 0;
    #1;
    chk("t7_valid", 32'(trace_valid), 0);
    chk("t7_cnt", commit_cnt, 0);
    chk("t7_done", 32'(done), 0);
    step(2);
    rst_n = 1;
    step(2);

    // randomized traffic
    rnd_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      cpu_run     = ($urandom_range(0, 7) != 0);
      gate_stall  = (c < 1500);
      trace_ready = (c < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
      trace_clr   = ($urandom_range(0, 99) == 0);
      step(1);
    end
    trace_clr = 0; rnd_mode = 0; nxt_commit = 0; trace_ready = 1; gate_stall = 1;
    drain(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got %0d errors", n_err);
    $fatal(1);
  end

endmodule
